alu_decode_unit: RTL and testbench



---
 rtl/alu_decode_unit.sv | 145 ++++++++++++++
 tb/tb_alu_decode_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_unit.sv
// Decode + execute stage: field split, control decode, ALU; registered write port, 1-cycle latency, no backpressure.
// Optional ALU_SHIFT_EN: enables SLL/SRL; otherwise those functs decode as unsupported and write nothing.
module alu_decode_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ir,
  input  logic [31:0] src_data,
  input  logic [31:0] reg_src1,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  dst_addr,
  output logic        wrt_sig,
  output logic [31:0] dst_data,
  output logic        zero,
  output logic        ovf
);

  typedef struct packed {
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       wrt;
    logic       alu_imm;
    logic       sext;
  } ctrl_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_BAD = 4'b1111;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rd;
  logic [15:0] imm;
  ctrl_t       ctrl;
  logic [3:0]  alu_ctr;
  logic [31:0] imm_ext;
  logic [31:0] opb;
  logic [31:0] result;
  logic        ovf_c;
  logic [4:0]  waddr;
  logic        wen;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign funct = ir[5:0];
  assign imm   = ir[15:0];

  always_comb begin
    ctrl = '0;
    case (op)
      6'b000000: ctrl = '{alu_op: 2'b10, reg_dst: 1'b1, wrt: 1'b1, alu_imm: 1'b0, sext: 1'b0};
      6'b001000: ctrl = '{alu_op: 2'b00, reg_dst: 1'b0, wrt: 1'b1, alu_imm: 1'b1, sext: 1'b1};
      6'b001101: ctrl = '{alu_op: 2'b11, reg_dst: 1'b0, wrt: 1'b1, alu_imm: 1'b1, sext: 1'b0};
      6'b100011: ctrl = '{alu_op: 2'b00, reg_dst: 1'b0, wrt: 1'b1, alu_imm: 1'b1, sext: 1'b1};
      6'b101011: ctrl = '{alu_op: 2'b00, reg_dst: 1'b0, wrt: 1'b0, alu_imm: 1'b1, sext: 1'b1};
      6'b000100: ctrl = '{alu_op: 2'b01, reg_dst: 1'b0, wrt: 1'b0, alu_imm: 1'b0, sext: 1'b0};
      default:   ctrl = '0;
    endcase
  end

  always_comb begin
    alu_ctr = ALU_BAD;
    case (ctrl.alu_op)
      2'b00: alu_ctr = ALU_ADD;
      2'b01: alu_ctr = ALU_SUB;
      2'b11: alu_ctr = ALU_OR;
      default: begin
        case (funct)
          6'b100000: alu_ctr = ALU_ADD;
          6'b100010: alu_ctr = ALU_SUB;
          6'b100100: alu_ctr = ALU_AND;
          6'b100101: alu_ctr = ALU_OR;
          6'b100111: alu_ctr = ALU_NOR;
          6'b101010: alu_ctr = ALU_SLT;
`ifdef ALU_SHIFT_EN
          6'b000000: alu_ctr = ALU_SLL;
          6'b000010: alu_ctr = ALU_SRL;
`endif
          default:   alu_ctr = ALU_BAD;
        endcase
      end
    endcase
  end

  assign imm_ext = ctrl.sext ? {{16{imm[15]}}, imm} : {16'h0000, imm};
  assign opb     = ctrl.alu_imm ? imm_ext : reg_src1;

`ifndef ALU_SHIFT_EN
  logic unused_shamt;
  assign unused_shamt = ^ir[10:6];
`endif

  // Overflow: result sign departs from A when B (ADD) or ~B (SUB) shares A's sign.
  always_comb begin
    result = '0;
    ovf_c  = 1'b0;
    case (alu_ctr)
      ALU_ADD: begin
        result = src_data + opb;
        ovf_c  = (src_data[31] == opb[31]) && (result[31] != src_data[31]);
      end
      ALU_SUB: begin
        result = src_data - opb;
        ovf_c  = (src_data[31] != opb[31]) && (result[31] != src_data[31]);
      end
      ALU_AND: result = src_data & opb;
      ALU_OR:  result = src_data | opb;
      ALU_NOR: result = ~(src_data | opb);
      ALU_SLT: result = {31'b0, $signed(src_data) < $signed(opb)};
`ifdef ALU_SHIFT_EN
      ALU_SLL: result = opb << ir[10:6];
      ALU_SRL: result = opb >> ir[10:6];
`endif
      default: result = '0;
    endcase
  end

  assign waddr = ctrl.reg_dst ? rd : rt;
  assign wen   = ctrl.wrt && (alu_ctr != ALU_BAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst_data <= '0;
      dst_addr <= '0;
      wrt_sig  <= 1'b0;
      zero     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      dst_data <= result;
      dst_addr <= waddr;
      wrt_sig  <= wen;
      zero     <= (result == 32'h0);
      ovf      <= ovf_c;
    end
  end

endmodule

// File: tb/tb_alu_decode_unit.sv
// Scoreboard bench for alu_decode_unit: directed vectors, mid-stream reset, then randomized traffic.
module tb_alu_decode_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ir = '0;
  logic [31:0] src_data = '0;
  logic [31:0] reg_src1 = '0;
  logic [4:0]  rs, rt, dst_addr;
  logic        wrt_sig, zero, ovf;
  logic [31:0] dst_data;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] data;
    logic [4:0]  addr;
    logic        wrt;
    logic        zero;
    logic        ovf;
  } exp_t;

  exp_t q[$];

  alu_decode_unit dut (
    .clk(clk), .rst(rst), .ir(ir), .src_data(src_data), .reg_src1(reg_src1),
    .rs(rs), .rt(rt), .dst_addr(dst_addr), .wrt_sig(wrt_sig),
    .dst_data(dst_data), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp,
                       input logic [31:0] instr);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s ir=%h got %h expected %h", name, instr, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int s, input int t, input int d, input int sh, input int fn);
    logic [31:0] w;
    w = {6'd0, 5'(s), 5'(t), 5'(d), 5'(sh), 6'(fn)};
    return w;
  endfunction

  function automatic logic [31:0] itype(input int o, input int s, input int t, input int im);
    logic [31:0] w;
    w = {6'(o), 5'(s), 5'(t), 16'(im)};
    return w;
  endfunction

  // Reference: ops computed as integer arithmetic on signed/unsigned values.
  function automatic exp_t model(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] rb);
    exp_t e;
    int unsigned opc, fn, sh;
    string kind;
    logic [31:0] b;
    logic writes, use_rd;
    longint sa, sb, s;
    opc = instr[31:26];
    fn  = instr[5:0];
    sh  = instr[10:6];
    use_rd = 1'b0;
    writes = 1'b0;
    b = rb;
    kind = "add";
    case (opc)
      0: begin
        use_rd = 1'b1; writes = 1'b1;
        case (fn)
          32: kind = "add";
          34: kind = "sub";
          36: kind = "and";
          37: kind = "or";
          39: kind = "nor";
          42: kind = "slt";
`ifdef ALU_SHIFT_EN
          0:  kind = "sll";
          2:  kind = "srl";
`endif
          default: kind = "bad";
        endcase
      end
      8:  begin writes = 1'b1; b = {{16{instr[15]}}, instr[15:0]}; end
      13: begin writes = 1'b1; kind = "or"; b = {16'h0, instr[15:0]}; end
      35: begin writes = 1'b1; b = {{16{instr[15]}}, instr[15:0]}; end
      43: b = {{16{instr[15]}}, instr[15:0]};
      4:  kind = "sub";
      default: kind = "add";
    endcase
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.ovf = 1'b0;
    e.data = '0;
    if (kind == "add" || kind == "sub") begin
      s = (kind == "add") ? sa + sb : sa - sb;
      e.data = s[31:0];
      e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else if (kind == "and") e.data = a & b;
    else if (kind == "or")  e.data = a | b;
    else if (kind == "nor") e.data = ~(a | b);
    else if (kind == "slt") e.data = (sa < sb) ? 32'd1 : 32'd0;
    else if (kind == "sll") begin
      s = (longint'(b) * (64'sd1 << sh));
      e.data = s[31:0];
    end
    else if (kind == "srl") e.data = 32'(longint'(b) / (64'sd1 << sh));
    else begin
      e.data = '0;
      writes = 1'b0;
    end
    e.instr = instr;
    e.wrt  = writes;
    e.zero = (e.data == 0);
    e.addr = use_rd ? instr[15:11] : instr[20:16];
    return e;
  endfunction

  // Call right after a falling edge: drives inputs, queues expectation, checks rs/rt.
  task automatic issue(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
    ir = instr;
    src_data = a;
    reg_src1 = b;
    q.push_back(model(instr, a, b));
    #1;
    check("rs", {27'd0, rs}, {27'd0, instr[25:21]}, instr);
    check("rt", {27'd0, rt}, {27'd0, instr[20:16]}, instr);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_dst_data"}, dst_data, 32'd0, ir);
    check({tag, "_dst_addr"}, {27'd0, dst_addr}, 32'd0, ir);
    check({tag, "_wrt_sig"}, {31'd0, wrt_sig}, 32'd0, ir);
    check({tag, "_zero"}, {31'd0, zero}, 32'd0, ir);
    check({tag, "_ovf"}, {31'd0, ovf}, 32'd0, ir);
  endtask

  // Monitor: every capture edge outside reset must match the oldest expectation.
  always begin
    @(posedge clk);
    #1;
    if (!rst && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("dst_data", dst_data, e.data, e.instr);
      check("dst_addr", {27'd0, dst_addr}, {27'd0, e.addr}, e.instr);
      check("wrt_sig", {31'd0, wrt_sig}, {31'd0, e.wrt}, e.instr);
      check("zero", {31'd0, zero}, {31'd0, e.zero}, e.instr);
      check("ovf", {31'd0, ovf}, {31'd0, e.ovf}, e.instr);
    end
  end

  logic [31:0] dir_ir [16];
  logic [31:0] dir_a  [16];
  logic [31:0] dir_b  [16];
  logic [31:0] specials [6];

  initial begin
    dir_ir[0]  = rtype(1, 2, 3, 0, 32);           dir_a[0]  = 7;            dir_b[0]  = 5;
    dir_ir[1]  = rtype(1, 2, 3, 0, 32);           dir_a[1]  = 32'h7FFFFFFF; dir_b[1]  = 1;
    dir_ir[2]  = rtype(4, 5, 6, 0, 34);           dir_a[2]  = 9;            dir_b[2]  = 9;
    dir_ir[3]  = rtype(4, 5, 7, 0, 42);           dir_a[3]  = 32'hFFFFFFFF; dir_b[3]  = 1;
    dir_ir[4]  = rtype(4, 5, 8, 0, 39);           dir_a[4]  = 0;            dir_b[4]  = 0;
    dir_ir[5]  = itype(8, 1, 9, 16'hFFFF);        dir_a[5]  = 5;            dir_b[5]  = 32'h1234;
    dir_ir[6]  = itype(13, 1, 10, 16'h8000);      dir_a[6]  = 0;            dir_b[6]  = 32'h1234;
    dir_ir[7]  = itype(43, 1, 11, 16'h0010);      dir_a[7]  = 100;          dir_b[7]  = 3;
    dir_ir[8]  = itype(4, 1, 12, 16'h0004);       dir_a[8]  = 6;            dir_b[8]  = 6;
    dir_ir[9]  = itype(63, 1, 13, 16'h0001);      dir_a[9]  = 2;            dir_b[9]  = 3;
    dir_ir[10] = rtype(1, 2, 14, 0, 63);          dir_a[10] = 2;            dir_b[10] = 3;
    dir_ir[11] = rtype(0, 2, 15, 4, 0);           dir_a[11] = 0;            dir_b[11] = 1;
    dir_ir[12] = rtype(0, 2, 16, 31, 2);          dir_a[12] = 0;            dir_b[12] = 32'h80000000;
    dir_ir[13] = 32'h0;                           dir_a[13] = 0;            dir_b[13] = 0;
    dir_ir[14] = itype(35, 3, 17, 16'hFFFC);      dir_a[14] = 32'h100;      dir_b[14] = 0;
    dir_ir[15] = rtype(1, 2, 18, 0, 34);          dir_a[15] = 32'h80000000; dir_b[15] = 1;
    specials[0] = 0; specials[1] = 1; specials[2] = 32'hFFFFFFFF;
    specials[3] = 32'h7FFFFFFF; specials[4] = 32'h80000000; specials[5] = 9;

    #3;
    check_cleared("reset_hold");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      issue(dir_ir[i], dir_a[i], dir_b[i]);
    end

    // Mid-stream reset: a nonzero result sits on the outputs, a new one is in flight.
    @(negedge clk);
    issue(rtype(1, 2, 3, 0, 32), 7, 5);
    @(negedge clk);
    issue(rtype(1, 2, 19, 0, 37), 32'hF0, 32'h0F);
    #1;
    rst = 1'b1;
    q.delete();
    #1;
    check_cleared("reset_async");
    @(posedge clk);
    #1;
    check_cleared("reset_edge");
    @(negedge clk);
    rst = 1'b0;
    issue(rtype(1, 2, 20, 0, 32), 7, 5);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] w, a, b;
      int unsigned opcs[8];
      int unsigned fns[9];
      opcs = '{0, 0, 8, 13, 35, 43, 4, $urandom_range(0, 63)};
      fns  = '{32, 34, 36, 37, 39, 42, 0, 2, $urandom_range(0, 63)};
      w = $urandom;
      w[31:26] = 6'(opcs[$urandom_range(0, 7)]);
      if (w[31:26] == 6'd0) w[5:0] = 6'(fns[$urandom_range(0, 8)]);
      a = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      @(negedge clk);
      issue(w, a, b);
    end

    @(posedge clk);
    #2;
    check("queue_drained", q.size(), 32'd0, ir);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
